imem_fetch_unit: RTL and testbench

//  Loadable, parametrised instruction memory with a request/valid fetch handshake and configurable wait-state latency.

---
 rtl/imem_fetch_unit.sv | 96 +++++++++
 tb/tb_imem_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_unit.sv
// Loadable instruction memory with a request/valid fetch handshake and programmable wait states.
// One fetch in flight at a time; the word is captured at acceptance and delivered LATENCY edges later.
module imem_fetch_unit #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 64,
  parameter int                 LATENCY  = 1,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              instr_oob,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_err
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [3:0]        LAT     = 4'(LATENCY);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_pend_word;
  logic              r_pend_oob;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              r_oob;
  logic              r_load_err;

  logic              w_fetch_oob;
  logic              w_load_oob;
  logic              w_accept;
  logic              w_done;
  logic [DATA_W-1:0] w_rd_word;

  // Full-width compares: an index beyond DEPTH must never alias onto a real word.
  assign w_fetch_oob = (pc >= DEPTH_A);
  assign w_load_oob  = (load_addr >= DEPTH_A);
  assign fetch_ready = (r_cnt <= 4'd1) || flush;
  assign w_accept    = fetch_req && fetch_ready;
  assign w_done      = (r_cnt == 4'd1) && !flush;
  assign w_rd_word   = w_fetch_oob ? NOP_WORD : r_mem[pc[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= NOP_WORD;
    end else if (load_en && !w_load_oob) begin
      r_mem[load_addr[IDX_W-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 4'd0;
      r_pend_word <= NOP_WORD;
      r_pend_oob  <= 1'b0;
      r_instr     <= NOP_WORD;
      r_valid     <= 1'b0;
      r_oob       <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_load_err <= load_en && w_load_oob;
      if (flush) begin
        r_cnt <= 4'd0;
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done) begin
        r_instr <= r_pend_word;
        r_oob   <= r_pend_oob;
        r_valid <= 1'b1;
      end
      // Acceptance overrides the decrement so a completing fetch can be chained.
      if (w_accept) begin
        r_cnt       <= LAT;
        r_pend_word <= w_rd_word;
        r_pend_oob  <= w_fetch_oob;
      end
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign instr_oob   = r_oob;
  assign load_err    = r_load_err;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: one instance at LATENCY=1 and one at LATENCY=3 driven in lockstep,
// checked by a timestamp-based reference model, a vector table and directed multi-cycle sequences.
module tb_imem_fetch_unit;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;

  logic        rdy   [2];
  logic [31:0] instr [2];
  logic        vld   [2];
  logic        oob   [2];
  logic        lerr  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_fetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(1), .NOP_WORD(32'h0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_ready(rdy[0]), .pc(pc), .flush(flush),
    .instr(instr[0]), .instr_valid(vld[0]), .instr_oob(oob[0]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .load_err(lerr[0]));

  imem_fetch_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .LATENCY(3), .NOP_WORD(32'h0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_ready(rdy[1]), .pc(pc), .flush(flush),
    .instr(instr[1]), .instr_valid(vld[1]), .instr_oob(oob[1]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .load_err(lerr[1]));

  // Reference model: memory image plus the edge number at which the in-flight fetch is due.
  logic [31:0] m_mem   [2][DEPTH];
  logic        m_act   [2];
  int          m_due   [2];
  logic [31:0] m_pword [2];
  logic        m_poob  [2];
  logic [31:0] m_instr [2];
  logic        m_vld   [2];
  logic        m_oob   [2];
  logic        m_lerr  [2];
  int          cyc = 0;

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic m_ready(int k);
    return !m_act[k] || (m_due[k] <= cyc) || flush;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
      m_act[k] = 0; m_due[k] = 0; m_pword[k] = '0; m_poob[k] = 0;
      m_instr[k] = '0; m_vld[k] = 0; m_oob[k] = 0; m_lerr[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic done;
      logic acc;
      done = m_act[k] && (m_due[k] == cyc);
      acc  = fetch_req && m_ready(k);
      m_vld[k] = 0;
      if (done && !flush) begin
        m_vld[k] = 1; m_instr[k] = m_pword[k]; m_oob[k] = m_poob[k];
      end
      if (done || flush) m_act[k] = 0;
      if (acc) begin
        m_act[k]   = 1;
        m_due[k]   = cyc + lat_of(k);
        m_poob[k]  = (pc >= 32'(DEPTH));
        m_pword[k] = m_poob[k] ? 32'h0 : m_mem[k][pc[5:0]];
      end
      m_lerr[k] = load_en && (load_addr >= 32'(DEPTH));
      if (load_en && load_addr < 32'(DEPTH)) m_mem[k][load_addr[5:0]] = load_data;
    end
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic req, input logic [31:0] p, input logic fl,
                        input logic ld, input logic [31:0] la, input logic [31:0] ldd);
    fetch_req = req; pc = p; flush = fl; load_en = ld; load_addr = la; load_data = ldd;
  endtask

  // One clock: ready is checked mid-cycle, registered outputs 1 time unit after the edge.
  task automatic step();
    @(negedge clk);
    chk("ready_l1", 32'(rdy[0]), 32'(m_ready(0)));
    chk("ready_l3", 32'(rdy[1]), 32'(m_ready(1)));
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "valid_l1" : "valid_l3", 32'(vld[k]),  32'(m_vld[k]));
      chk(k == 0 ? "instr_l1" : "instr_l3", instr[k],     m_instr[k]);
      chk(k == 0 ? "oob_l1"   : "oob_l3",   32'(oob[k]),  32'(m_oob[k]));
      chk(k == 0 ? "lerr_l1"  : "lerr_l3",  32'(lerr[k]), 32'(m_lerr[k]));
    end
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        fl;
    logic        ld;
    logic [31:0] la;
    logic [31:0] ldd;
    logic        ev;
    logic [31:0] ei;
    logic        eo;
    logic        el;
  } vec_t;

  vec_t tbl [22];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Hand-derived LATENCY=1 expectations (outputs after each edge)
    tbl[0]  = '{1, 32'd0,          0, 0, 32'd0,  32'h0,        0, 32'h0,        0, 0};
    tbl[1]  = '{1, 32'd1,          0, 0, 32'd0,  32'h0,        1, 32'h0,        0, 0};
    tbl[2]  = '{1, 32'd2,          0, 0, 32'd0,  32'h0,        1, 32'h0,        0, 0};
    tbl[3]  = '{1, 32'd3,          0, 0, 32'd0,  32'h0,        1, 32'h0,        0, 0};
    tbl[4]  = '{0, 32'd0,          0, 1, 32'd0,  32'hE400FFFF, 1, 32'h0,        0, 0};
    tbl[5]  = '{0, 32'd0,          0, 1, 32'd1,  32'hE800FFFF, 0, 32'h0,        0, 0};
    tbl[6]  = '{1, 32'd0,          0, 0, 32'd0,  32'h0,        0, 32'h0,        0, 0};
    tbl[7]  = '{1, 32'd1,          0, 0, 32'd0,  32'h0,        1, 32'hE400FFFF, 0, 0};
    tbl[8]  = '{0, 32'd0,          0, 0, 32'd0,  32'h0,        1, 32'hE800FFFF, 0, 0};
    tbl[9]  = '{1, 32'd64,         0, 0, 32'd0,  32'h0,        0, 32'hE800FFFF, 0, 0};
    tbl[10] = '{0, 32'd0,          0, 1, 32'd64, 32'h12345678, 1, 32'h0,        1, 1};
    tbl[11] = '{1, 32'd0,          0, 0, 32'd0,  32'h0,        0, 32'h0,        1, 0};
    tbl[12] = '{0, 32'd0,          0, 0, 32'd0,  32'h0,        1, 32'hE400FFFF, 0, 0};
    tbl[13] = '{0, 32'd0,          0, 1, 32'd5,  32'h11110000, 0, 32'hE400FFFF, 0, 0};
    tbl[14] = '{1, 32'd5,          0, 1, 32'd5,  32'hAAAA0000, 0, 32'hE400FFFF, 0, 0};
    tbl[15] = '{0, 32'd0,          0, 0, 32'd0,  32'h0,        1, 32'h11110000, 0, 0};
    tbl[16] = '{1, 32'd5,          0, 0, 32'd0,  32'h0,        0, 32'h11110000, 0, 0};
    tbl[17] = '{1, 32'h80000001,   0, 0, 32'd0,  32'h0,        1, 32'hAAAA0000, 0, 0};
    tbl[18] = '{0, 32'd0,          0, 0, 32'd0,  32'h0,        1, 32'h0,        1, 0};
    tbl[19] = '{1, 32'd1,          1, 0, 32'd0,  32'h0,        0, 32'h0,        1, 0};
    tbl[20] = '{1, 32'd0,          1, 0, 32'd0,  32'h0,        0, 32'h0,        1, 0};
    tbl[21] = '{0, 32'd0,          0, 0, 32'd0,  32'h0,        1, 32'hE400FFFF, 0, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", 32'(vld[k]), 32'h0);
      chk("rst_instr", instr[k], 32'h0);
      chk("rst_oob", 32'(oob[k]), 32'h0);
      chk("rst_lerr", 32'(lerr[k]), 32'h0);
      chk("rst_ready", 32'(rdy[k]), 32'h1);
    end
    #3 rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      set_in(tbl[i].req, tbl[i].pc, tbl[i].fl, tbl[i].ld, tbl[i].la, tbl[i].ldd);
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(vld[0]), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_instr", i), instr[0], tbl[i].ei);
      chk($sformatf("tbl%0d_oob", i), 32'(oob[0]), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_lerr", i), 32'(lerr[0]), 32'(tbl[i].el));
    end
    idle(4);

    // LATENCY=3 fetch of pc=1: ready low for two cycles, single pulse after the third edge
    set_in(1, 1, 0, 0, 0, 0);
    step();
    chk("l3_e0_valid", 32'(vld[1]), 32'h0);
    set_in(0, 0, 0, 0, 0, 0);
    #1 chk("l3_e1_ready", 32'(rdy[1]), 32'h0);
    step();
    chk("l3_e1_valid", 32'(vld[1]), 32'h0);
    #1 chk("l3_e2_ready", 32'(rdy[1]), 32'h0);
    step();
    chk("l3_e2_valid", 32'(vld[1]), 32'h0);
    #1 chk("l3_e3_ready", 32'(rdy[1]), 32'h1);
    step();
    chk("l3_e3_valid", 32'(vld[1]), 32'h1);
    chk("l3_e3_instr", instr[1], 32'hE800FFFF);
    step();
    chk("l3_e4_valid", 32'(vld[1]), 32'h0);

    // Flush two cycles after a pc=2 fetch, redirecting to pc=9
    set_in(0, 0, 0, 1, 2, 32'h22220002); step();
    set_in(0, 0, 0, 1, 9, 32'h99990009); step();
    set_in(1, 2, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0); step();
    set_in(1, 9, 1, 0, 0, 0);
    #1 chk("flush_ready", 32'(rdy[1]), 32'h1);
    step();
    chk("flush_e0_valid", 32'(vld[1]), 32'h0);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk("flush_e1_valid", 32'(vld[1]), 32'h0);
    step();
    chk("flush_e2_valid", 32'(vld[1]), 32'h0);
    step();
    chk("flush_e3_valid", 32'(vld[1]), 32'h1);
    chk("flush_e3_instr", instr[1], 32'h99990009);

    // Reset asserted while a fetch is in flight
    set_in(1, 1, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0); step();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("midrst_instr", instr[1], 32'h0);
    chk("midrst_ready", 32'(rdy[1]), 32'h1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_novalid", 32'(vld[1]), 32'h0);
    end
    set_in(1, 1, 0, 0, 0, 0); step();
    idle(3);
    chk("midrst_cleared_valid", 32'(vld[1]), 32'h1);
    chk("midrst_cleared_instr", instr[1], 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 70));
      set_in($urandom_range(0, 2) != 0, ra, $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) == 0, 32'($urandom_range(0, 70)), $urandom);
      step();
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
